apb_timer_regs: RTL and testbench
=================================

Name: apb_timer_regs

Overview:
- Register-bank peripheral that consumes the simple request/response interface produced by the APB slave front-end (req_valid/addr/write/wdata in, resp_valid/rdata/err out).
- Implements a prescaled 64-bit up-counter with a 64-bit compare, sticky pending flag, optional auto-reload and a level interrupt.
- Sits directly downstream of the APB slave stage inside a timer peripheral wrapper.

Parameters:
- presc_bits, 16, width of PRESCALE register and internal prescale counter (1..32).

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_req_valid  in  1  request strobe from the APB slave, single-cycle pulse
- i_req_addr  in  32  byte address; only bits [11:0] are decoded
- i_req_write  in  1  1=write, 0=read
- i_req_wdata  in  32  write data
- o_resp_valid  out  1  response strobe, one-cycle pulse
- o_resp_rdata  out  32  read data; 0 on writes and errors
- o_resp_err  out  1  slave error, qualified by o_resp_valid
- o_irq  out  1  interrupt level = pending & CTRL.irq_ena
- o_tick  out  1  one-cycle pulse on every counter increment

Behaviour:
- Reset: i_rst is synchronous and active-high on i_clk. When i_rst=1 at a rising edge, every register clears: CTRL, PRESCALE, CNT, CMP, pending, hi-shadow, prescale counter, resp regs. All outputs are 0 the cycle after. A transaction in flight when reset asserts is dropped: no o_resp_valid.
- Handshake:
  - No ready signal; every i_req_valid is accepted.
  - o_resp_valid is asserted exactly 1 cycle after i_req_valid, with rdata/err registered in the same edge.
  - Back-to-back requests on consecutive cycles are legal and produce back-to-back responses.
- Register map (word offset, 32-bit):
  - 0x00 CTRL RW: [0]=enable, [1]=irq_ena, [2]=auto_reload; other bits read 0.
  - 0x04 PRESCALE RW: [presc_bits-1:0]; upper bits read 0.
  - 0x08 CNT_LO RW. A read returns cnt[31:0] and latches cnt[63:32] into hi_shadow.
  - 0x0C CNT_HI RW. A read returns hi_shadow, not the live value.
  - 0x10 CMP_LO RW, 0x14 CMP_HI RW.
  - 0x18 STATUS: [0]=pending, read; write-1-to-clear.
- Errors: addr[11:0] > 0x18, or addr[1:0] != 0, gives o_resp_err=1 and rdata=0. Erroneous writes have no side effect.
- Prescaler, while CTRL.enable=1 each cycle:
  - If presc_cnt == PRESCALE: presc_cnt<=0 and tick=1.
  - Otherwise presc_cnt<=presc_cnt+1.
  - PRESCALE=0 gives a tick every cycle.
  - With enable=0, presc_cnt holds and tick=0.
  - A write to PRESCALE or CTRL clears presc_cnt.
- Counter, on tick:
  - cnt_next = cnt+1, modulo 2^64; 0xFFFF_FFFF_FFFF_FFFF wraps to 0 with no flag.
  - If cnt_next == CMP: pending<=1, and if auto_reload=1 then cnt<=0, else cnt<=cnt_next.
- Priorities in the same cycle:
  - A CNT_LO/CNT_HI write overrides the tick update of that half. The other half still takes the tick result, but carry into a written half is lost.
  - A STATUS W1C coinciding with a compare match leaves pending=1 (set wins).
  - Writing CMP equal to the current cnt does not set pending; only a tick-produced match does.
- o_tick is registered: it follows the internal tick by one cycle.
- o_irq is combinational from registered pending and irq_ena.

Test Plan:
- Reset then read 0x00..0x18 -> each resp 1 cycle after req, rdata=0, err=0. Read 0x1C -> err=1, rdata=0. Read 0x02 -> err=1.
- PRESCALE=3, CTRL=1, wait 40 cycles -> o_tick every 4th cycle. Read CNT_LO -> value 10 ±1, matching the tick count.
- CNT_LO=0xFFFF_FFFE, CNT_HI=0, PRESCALE=0, enable -> after 3 ticks a CNT_LO read returns 1 and a following CNT_HI read returns 1 (shadow). A CNT_HI read before any CNT_LO read returns the stale shadow.
- CMP=5, CTRL=0x7, PRESCALE=0 -> pending and o_irq set on match, cnt reloads to 0, pending stays 1 on the next match. W1C STATUS=1 -> o_irq drops, then re-asserts at the next match.
- W1C issued in the exact cycle of a match -> pending remains 1. CNT write in a tick cycle -> the read back equals the written value.
- Assert i_rst in the cycle after a read request -> no o_resp_valid, all registers read 0 afterwards.

Source files
------------

// File: rtl/apb_timer_regs.sv
// apb_timer_regs: timer register bank behind the APB slave front-end.
// A prescaled 64-bit up-counter with a 64-bit compare, a sticky pending flag,
// optional auto-reload and a level interrupt.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid         single-cycle request strobe (always accepted)
//   i_req_addr          byte address, bits [11:0] decoded
//   i_req_write         1 = write, 0 = read
//   i_req_wdata         write data
//   o_resp_valid        response strobe, one cycle after the request
//   o_resp_rdata        read data (0 on writes and errors)
//   o_resp_err          bad address or misaligned access
//   o_irq               pending & irq_ena
//   o_tick              registered copy of the internal counter tick
//
// Register map: 0x00 CTRL {auto_reload, irq_ena, enable}, 0x04 PRESCALE,
// 0x08 CNT_LO (read latches CNT_HI shadow), 0x0C CNT_HI (reads shadow),
// 0x10 CMP_LO, 0x14 CMP_HI, 0x18 STATUS {pending} write-1-to-clear.
module apb_timer_regs #(
  parameter int unsigned presc_bits = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_write,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_irq,
  output logic        o_tick
);

  logic                  ctrl_en;
  logic                  ctrl_irq_ena;
  logic                  ctrl_auto;
  logic [presc_bits-1:0] prescale;
  logic [presc_bits-1:0] presc_cnt;
  logic [63:0]           cnt;
  logic [63:0]           cmp;
  logic                  pending;
  logic [31:0]           hi_shadow;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  tick_q;

  logic [11:0]           addr;
  logic                  addr_ok;
  logic                  wr;
  logic                  rd;
  logic                  wr_ctrl, wr_presc, wr_cnt_lo, wr_cnt_hi;
  logic                  wr_cmp_lo, wr_cmp_hi, wr_status;
  logic                  tick;
  logic                  match;
  logic [63:0]           cnt_inc;
  logic [63:0]           cnt_nxt;
  logic [presc_bits-1:0] presc_nxt;
  logic [31:0]           rdata_mux;

  // Decode
  assign addr    = i_req_addr[11:0];
  assign addr_ok = (addr <= 12'h018) && (addr[1:0] == 2'b00);
  assign wr      = i_req_valid &  i_req_write & addr_ok;
  assign rd      = i_req_valid & ~i_req_write & addr_ok;

  assign wr_ctrl   = wr && (addr == 12'h000);
  assign wr_presc  = wr && (addr == 12'h004);
  assign wr_cnt_lo = wr && (addr == 12'h008);
  assign wr_cnt_hi = wr && (addr == 12'h00C);
  assign wr_cmp_lo = wr && (addr == 12'h010);
  assign wr_cmp_hi = wr && (addr == 12'h014);
  assign wr_status = wr && (addr == 12'h018);

  // Prescaler
  assign tick = ctrl_en && (presc_cnt == prescale);

  always_comb begin
    presc_nxt = presc_cnt;
    if (ctrl_en) begin
      presc_nxt = tick ? '0 : presc_cnt + 1'b1;
    end
    if (wr_ctrl || wr_presc) begin
      presc_nxt = '0;
    end
  end

  // Counter: tick result first, then a software write replaces only the
  // written half, so a carry into that half is discarded.
  assign cnt_inc = cnt + 64'd1;
  assign match   = tick && (cnt_inc == cmp);

  always_comb begin
    cnt_nxt = cnt;
    if (tick) begin
      cnt_nxt = (match && ctrl_auto) ? '0 : cnt_inc;
    end
    if (wr_cnt_lo) begin
      cnt_nxt[31:0] = i_req_wdata;
    end
    if (wr_cnt_hi) begin
      cnt_nxt[63:32] = i_req_wdata;
    end
  end

  // Read mux
  always_comb begin
    rdata_mux = '0;
    case (addr)
      12'h000: rdata_mux = {29'd0, ctrl_auto, ctrl_irq_ena, ctrl_en};
      12'h004: rdata_mux = 32'(prescale);
      12'h008: rdata_mux = cnt[31:0];
      12'h00C: rdata_mux = hi_shadow;
      12'h010: rdata_mux = cmp[31:0];
      12'h014: rdata_mux = cmp[63:32];
      12'h018: rdata_mux = {31'd0, pending};
      default: rdata_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl_en      <= 1'b0;
      ctrl_irq_ena <= 1'b0;
      ctrl_auto    <= 1'b0;
      prescale     <= '0;
      presc_cnt    <= '0;
      cnt          <= '0;
      cmp          <= '0;
      pending      <= 1'b0;
      hi_shadow    <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      presc_cnt  <= presc_nxt;
      cnt        <= cnt_nxt;
      tick_q     <= tick;
      resp_valid <= i_req_valid;
      resp_err   <= i_req_valid & ~addr_ok;
      resp_rdata <= rd ? rdata_mux : '0;

      if (wr_ctrl) begin
        ctrl_en      <= i_req_wdata[0];
        ctrl_irq_ena <= i_req_wdata[1];
        ctrl_auto    <= i_req_wdata[2];
      end
      if (wr_presc) begin
        prescale <= i_req_wdata[presc_bits-1:0];
      end
      if (wr_cmp_lo) begin
        cmp[31:0] <= i_req_wdata;
      end
      if (wr_cmp_hi) begin
        cmp[63:32] <= i_req_wdata;
      end
      if (rd && (addr == 12'h008)) begin
        hi_shadow <= cnt[63:32];
      end

      // A match in the same cycle as a clear keeps the flag set.
      if (match) begin
        pending <= 1'b1;
      end else if (wr_status && i_req_wdata[0]) begin
        pending <= 1'b0;
      end
    end
  end

  // Gating with i_rst drops a response that would appear in the reset cycle.
  assign o_resp_valid = resp_valid & ~i_rst;
  assign o_resp_err   = resp_err & ~i_rst;
  assign o_resp_rdata = resp_rdata;
  assign o_irq        = pending & ctrl_irq_ena;
  assign o_tick       = tick_q;

endmodule

// File: tb/tb_apb_timer_regs.sv
module tb_apb_timer_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        irq;
  logic        tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        dc;
    int          due;
  } exp_t;
  exp_t sb[$];

  int tick_total = 0;
  bit tick_chk = 0;
  bit have_prev = 0;
  int prev_tick = 0;

  localparam logic [31:0] A_CTRL = 32'h00, A_PRESC = 32'h04, A_CNT_LO = 32'h08,
                          A_CNT_HI = 32'h0C, A_CMP_LO = 32'h10, A_CMP_HI = 32'h14,
                          A_STATUS = 32'h18;

  apb_timer_regs #(.presc_bits(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_addr  (req_addr),
    .i_req_write (req_write),
    .i_req_wdata (req_wdata),
    .o_resp_valid(resp_valid),
    .o_resp_rdata(resp_rdata),
    .o_resp_err  (resp_err),
    .o_irq       (irq),
    .o_tick      (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response scoreboard
  always @(negedge clk) begin
    if (resp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.due !== cyc) begin
          errors++;
          $display("FAIL resp_latency: got cycle %0d, required %0d", cyc, e.due);
        end
        if (resp_err !== e.err) begin
          errors++;
          $display("FAIL resp_err: got %0b, required %0b (cycle %0d)", resp_err, e.err, cyc);
        end
        if (!e.dc && resp_rdata !== e.rdata) begin
          errors++;
          $display("FAIL resp_rdata: got %08h, required %08h (cycle %0d)", resp_rdata, e.rdata, cyc);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_resp: got none, required response at cycle %0d", e.due);
    end
  end

  // o_tick spacing monitor
  always @(negedge clk) begin
    if (tick) begin
      tick_total++;
      if (tick_chk) begin
        if (have_prev) begin
          checks++;
          if (cyc - prev_tick != 4) begin
            errors++;
            $display("FAIL tick_spacing: got %0d cycles, required 4", cyc - prev_tick);
          end
        end
        prev_tick = cyc;
        have_prev = 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input logic exp_err, input logic dc,
                     input logic push);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    if (push) sb.push_back('{exp, exp_err, dc, cyc + 1});
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    req(1'b1, a, d, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rd_exp(input logic [31:0] a, input logic [31:0] exp);
    req(1'b0, a, 32'h0, exp, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rd_get(input logic [31:0] a, output logic [31:0] d);
    req(1'b0, a, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    d = resp_rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_irq(input string name, input logic exp);
    checks++;
    if (irq !== exp) begin
      errors++;
      $display("FAIL %s: got irq=%0b, required %0b", name, irq, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({resp_valid, resp_err, irq, tick} !== 4'b0 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL %s: got valid=%0b err=%0b irq=%0b tick=%0b rdata=%08h, required all 0",
               name, resp_valid, resp_err, irq, tick, resp_rdata);
    end
  endtask

  task automatic read_all_zero();
    for (int unsigned i = 0; i <= 6; i++) rd_exp(32'(i * 4), 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_outputs_zero("reset_outputs");
    read_all_zero();
  endtask

  task automatic test_errors();
    req(1'b0, 32'h1C, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    req(1'b0, 32'h02, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    // Misaligned write must not reach CTRL
    req(1'b1, 32'h01, 32'h7, 32'h0, 1'b1, 1'b0, 1'b1);
    req(1'b1, 32'h20, 32'h7, 32'h0, 1'b1, 1'b0, 1'b1);
    rd_exp(A_CTRL, 32'h0);
    // Upper address bits are not decoded
    req(1'b0, 32'h0000_1018, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    wr(A_CMP_LO, 32'hDEAD_BEEF);
    wr(A_CMP_HI, 32'h1234_5678);
    wr(A_PRESC,  32'hFFFF_ABCD);
    wr(A_CTRL,   32'hFFFF_FFF8);
    rd_exp(A_CMP_LO, 32'hDEAD_BEEF);
    rd_exp(A_CMP_HI, 32'h1234_5678);
    rd_exp(A_PRESC,  32'h0000_ABCD);
    rd_exp(A_CTRL,   32'h0);
    wr(A_CMP_LO, 32'h0);
    wr(A_CMP_HI, 32'h0);
    wr(A_PRESC,  32'h0);
  endtask

  task automatic test_prescale();
    logic [31:0] v;
    int start;
    wr(A_CNT_LO, 32'h0);
    wr(A_CNT_HI, 32'h0);
    wr(A_PRESC, 32'd3);
    have_prev = 0;
    tick_chk  = 1;
    start = tick_total;
    wr(A_CTRL, 32'h1);
    idle(40);
    wr(A_CTRL, 32'h0);
    idle(2);
    tick_chk = 0;
    rd_get(A_CNT_LO, v);
    checks++;
    if (v !== 32'(tick_total - start)) begin
      errors++;
      $display("FAIL cnt_vs_ticks: got %0d, required %0d", v, tick_total - start);
    end
    checks++;
    if (v !== 32'd10) begin
      errors++;
      $display("FAIL cnt_after_40: got %0d, required 10", v);
    end
  endtask

  task automatic test_wrap();
    wr(A_PRESC, 32'h0);
    wr(A_CNT_LO, 32'hFFFF_FFFE);
    wr(A_CNT_HI, 32'h0);
    wr(A_CTRL, 32'h1);
    idle(2);
    wr(A_CTRL, 32'h0);
    rd_exp(A_CNT_HI, 32'h0);          // stale shadow
    rd_exp(A_CNT_LO, 32'h1);
    rd_exp(A_CNT_HI, 32'h1);
    // Full 64-bit wrap sets no flag
    wr(A_CMP_LO, 32'd5);
    wr(A_CNT_LO, 32'hFFFF_FFFF);
    wr(A_CNT_HI, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h0);
    rd_exp(A_CNT_LO, 32'h0);
    rd_exp(A_CNT_HI, 32'h0);
    rd_exp(A_STATUS, 32'h0);
  endtask

  task automatic test_compare();
    wr(A_CNT_LO, 32'h0);
    wr(A_CNT_HI, 32'h0);
    wr(A_CMP_LO, 32'd5);
    wr(A_CMP_HI, 32'h0);
    wr(A_PRESC, 32'h0);
    wr(A_STATUS, 32'h1);
    wr(A_CTRL, 32'h7);          // ticks begin on the following edge
    idle(4);
    check_irq("irq_before_match", 1'b0);
    idle(1);
    check_irq("irq_on_match", 1'b1);
    idle(1);
    wr(A_STATUS, 32'h1);
    check_irq("irq_after_w1c", 1'b0);
    idle(2);
    check_irq("irq_before_rematch", 1'b0);
    idle(1);
    check_irq("irq_rematch", 1'b1);
    idle(4);
    wr(A_STATUS, 32'h1);        // coincides with the next match
    check_irq("irq_w1c_vs_match", 1'b1);
    rd_exp(A_CNT_LO, 32'h0);    // reloaded
    rd_exp(A_STATUS, 32'h1);
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
    rd_exp(A_STATUS, 32'h0);
    // CMP written equal to cnt does not set pending
    wr(A_CNT_LO, 32'd9);
    wr(A_CMP_LO, 32'd9);
    rd_exp(A_STATUS, 32'h0);
  endtask

  task automatic test_cnt_write_on_tick();
    wr(A_CMP_LO, 32'hFFFF_FFFF);
    wr(A_CNT_HI, 32'h0);
    wr(A_CTRL, 32'h1);
    idle(2);
    wr(A_CNT_LO, 32'h0000_1234);
    rd_exp(A_CNT_LO, 32'h0000_1234);
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_reset_drop();
    wr(A_CTRL, 32'h6);
    wr(A_PRESC, 32'd5);
    wr(A_CMP_LO, 32'd9);
    wr(A_CNT_LO, 32'd3);
    req(1'b0, A_CTRL, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop: got resp_valid=%0b, required 0", resp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    check_outputs_zero("post_reset_outputs");
    read_all_zero();
  endtask

  initial begin
    test_reset();
    test_errors();
    test_back_to_back();
    test_prescale();
    test_wrap();
    test_compare();
    test_cnt_write_on_tick();
    test_reset_drop();
    idle(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
